// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
//
// Purpose:
//    Fractional-N baud-rate generator for a UART. The block produces an
//    oversample tick (tick_ovs) every brd_int (+ fractional carry) clock
//    cycles. From that tick it derives:
//       - tick_mid  : the mid-bit tick, used by the RX sampler
//       - tick_baud : the bit-rate tick, used by the TX shifter
//
// Configuration macro:
//    UART_BAUD_FRACTIONAL_EN
//       defined   : the fractional accumulator and carry path are built.
//       undefined : brd_frac is ignored and the period is max(brd_int,1).
//
// Ports:
//    clk        in   1            single clock, rising edge
//    reset      in   1            synchronous, active-low reset
//    en         in   1            count enable; low freezes all counters
//    brd_int    in   DIV_W        integer divisor (clk cycles per ovs tick)
//    brd_frac   in   FRAC_W       fractional divisor (1/2^FRAC_W cycle units)
//    brd_load   in   1            strobe: capture divisor and restart
//    tick_ovs   out  1            oversample-rate pulse
//    tick_mid   out  1            mid-bit pulse
//    tick_baud  out  1            bit-rate pulse
//    ovs_cnt    out  $clog2(OVS)  current oversample phase
// -----------------------------------------------------------------------------
module uart_baud_gen #(
   parameter int               DIV_W       = 16,
   parameter int               FRAC_W      = 4,
   parameter int               OVS         = 16,
   parameter logic [DIV_W-1:0] DEFAULT_BRD = 16'd27
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    en,
   input  logic [DIV_W-1:0]        brd_int,
   input  logic [FRAC_W-1:0]       brd_frac,
   input  logic                    brd_load,
   output logic                    tick_ovs,
   output logic                    tick_mid,
   output logic                    tick_baud,
   output logic [$clog2(OVS)-1:0]  ovs_cnt
);

   localparam int               CNT_W        = $clog2(OVS);
   localparam logic [CNT_W-1:0] OVS_LAST     = CNT_W'(OVS - 1);
   localparam logic [CNT_W-1:0] OVS_MID_PREV = CNT_W'(OVS / 2 - 1);

   logic [DIV_W-1:0] brd_act_q, brd_act_d;
   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [CNT_W-1:0] ovs_cnt_q, ovs_cnt_d;
   logic             tick_ovs_q, tick_ovs_d;
   logic             tick_mid_q, tick_mid_d;
   logic             tick_baud_q, tick_baud_d;

   logic [DIV_W-1:0] eff_int_s;
   logic             carry_s;
   logic [DIV_W:0]   last_s;
   logic             term_s;

   // Effective divisor: a programmed zero behaves as one (tick every cycle)
   always_comb begin
      if (brd_act_q == {DIV_W{1'b0}}) begin
         eff_int_s = DIV_W'(1);
      end else begin
         eff_int_s = brd_act_q;
      end
   end

   // Terminal count is P-1 with P = eff_int + carry; one extra bit so that
   // P = 2^DIV_W (max divisor plus carry) cannot overflow.
   assign last_s = {1'b0, eff_int_s} + {{DIV_W{1'b0}}, carry_s} - (DIV_W + 1)'(1);
   assign term_s = ({1'b0, div_cnt_q} == last_s);

   // Next-state for divisor, counters and tick pulses; load beats counting
   always_comb begin
      brd_act_d   = brd_act_q;
      div_cnt_d   = div_cnt_q;
      ovs_cnt_d   = ovs_cnt_q;
      tick_ovs_d  = 1'b0;
      tick_mid_d  = 1'b0;
      tick_baud_d = 1'b0;
      if (brd_load) begin
         brd_act_d = brd_int;
         div_cnt_d = {DIV_W{1'b0}};
         ovs_cnt_d = {CNT_W{1'b0}};
      end else if (en) begin
         if (term_s) begin
            div_cnt_d   = {DIV_W{1'b0}};
            // OVS is a power of two, so the add wraps OVS-1 -> 0 naturally
            ovs_cnt_d   = ovs_cnt_q + CNT_W'(1);
            tick_ovs_d  = 1'b1;
            tick_baud_d = (ovs_cnt_q == OVS_LAST);
            tick_mid_d  = (ovs_cnt_q == OVS_MID_PREV);
         end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
         end
      end else begin
         div_cnt_d = div_cnt_q;
         ovs_cnt_d = ovs_cnt_q;
      end
   end

   // State registers; reset abandons any period in progress
   always_ff @(posedge clk) begin
      if (!reset) begin
         brd_act_q   <= DEFAULT_BRD;
         div_cnt_q   <= {DIV_W{1'b0}};
         ovs_cnt_q   <= {CNT_W{1'b0}};
         tick_ovs_q  <= 1'b0;
         tick_mid_q  <= 1'b0;
         tick_baud_q <= 1'b0;
      end else begin
         brd_act_q   <= brd_act_d;
         div_cnt_q   <= div_cnt_d;
         ovs_cnt_q   <= ovs_cnt_d;
         tick_ovs_q  <= tick_ovs_d;
         tick_mid_q  <= tick_mid_d;
         tick_baud_q <= tick_baud_d;
      end
   end

`ifdef UART_BAUD_FRACTIONAL_EN
   logic [FRAC_W-1:0] frac_act_q, frac_act_d;
   logic [FRAC_W-1:0] frac_acc_q, frac_acc_d;
   logic              carry_q, carry_d;
   logic [FRAC_W:0]   frac_sum_s;

   assign frac_sum_s = {1'b0, frac_acc_q} + {1'b0, frac_act_q};
   // The carry used for this period was produced at the previous tick
   assign carry_s    = carry_q;

   // Fractional accumulator advances once per oversample tick
   always_comb begin
      frac_act_d = frac_act_q;
      frac_acc_d = frac_acc_q;
      carry_d    = carry_q;
      if (brd_load) begin
         frac_act_d = brd_frac;
         frac_acc_d = {FRAC_W{1'b0}};
         carry_d    = 1'b0;
      end else if (en && term_s) begin
         frac_acc_d = frac_sum_s[FRAC_W-1:0];
         carry_d    = frac_sum_s[FRAC_W];
      end else begin
         frac_acc_d = frac_acc_q;
         carry_d    = carry_q;
      end
   end

   // Fractional state registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         frac_act_q <= {FRAC_W{1'b0}};
         frac_acc_q <= {FRAC_W{1'b0}};
         carry_q    <= 1'b0;
      end else begin
         frac_act_q <= frac_act_d;
         frac_acc_q <= frac_acc_d;
         carry_q    <= carry_d;
      end
   end
`else
   logic unused_frac_s;

   // Integer-only build: no carry, brd_frac has no effect
   assign carry_s       = 1'b0;
   assign unused_frac_s = ^brd_frac;
`endif

   assign tick_ovs  = tick_ovs_q;
   assign tick_mid  = tick_mid_q;
   assign tick_baud = tick_baud_q;
   assign ovs_cnt   = ovs_cnt_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// -----------------------------------------------------------------------------
// tb_uart_baud_gen
//
// Self-checking bench for uart_baud_gen (default parameters). The reference
// model keeps a count of ticks and of enabled cycles into the current period.
// Period k after a load is eff + floor(k*frac/16) - floor((k-1)*frac/16),
// which is the closed form of the fractional accumulator's carry sequence.
// -----------------------------------------------------------------------------
module tb_uart_baud_gen;

   logic        clk = 1'b0;
   logic        reset;
   logic        en;
   logic [15:0] brd_int;
   logic [3:0]  brd_frac;
   logic        brd_load;
   logic        tick_ovs;
   logic        tick_mid;
   logic        tick_baud;
   logic [3:0]  ovs_cnt;

   int n_cmp  = 0;
   int n_fail = 0;

   // reference model state
   int         m_eff     = 27;
   int         m_frac    = 0;
   int         m_elapsed = 0;
   int         m_ticks   = 0;
   logic [6:0] exp_vec   = 7'd0;

   uart_baud_gen dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .brd_int   (brd_int),
      .brd_frac  (brd_frac),
      .brd_load  (brd_load),
      .tick_ovs  (tick_ovs),
      .tick_mid  (tick_mid),
      .tick_baud (tick_baud),
      .ovs_cnt   (ovs_cnt)
   );

   always #5 clk = ~clk;

   function automatic int m_period(input int k);
      if (k == 0) return m_eff;
      return m_eff + (k * m_frac) / 16 - ((k - 1) * m_frac) / 16;
   endfunction

   // advance one clock, update the model from the inputs seen at that edge
   task automatic step();
      logic e_ovs, e_mid, e_baud;
      @(posedge clk);
      e_ovs = 1'b0; e_mid = 1'b0; e_baud = 1'b0;
      if (!reset) begin
         m_eff = 27; m_frac = 0; m_elapsed = 0; m_ticks = 0;
      end else if (brd_load) begin
         m_eff = (brd_int == 16'd0) ? 1 : int'(brd_int);
`ifdef UART_BAUD_FRACTIONAL_EN
         m_frac = int'(brd_frac);
`else
         m_frac = 0;
`endif
         m_elapsed = 0; m_ticks = 0;
      end else if (en) begin
         m_elapsed++;
         if (m_elapsed == m_period(m_ticks)) begin
            m_ticks++;
            m_elapsed = 0;
            e_ovs  = 1'b1;
            e_baud = (m_ticks % 16 == 0);
            e_mid  = (m_ticks % 16 == 8);
         end
      end
      exp_vec = {e_ovs, e_mid, e_baud, 4'(m_ticks % 16)};
      #1;
   endtask

   task automatic do_load(input logic [15:0] bi, input logic [3:0] bf);
      brd_load = 1'b1; brd_int = bi; brd_frac = bf;
      step();
      n_cmp++;
      if ({tick_ovs, tick_mid, tick_baud, ovs_cnt} !== exp_vec) begin
         n_fail++;
         $display("FAIL load_cycle: got %b expected %b", {tick_ovs, tick_mid, tick_baud, ovs_cnt}, exp_vec);
      end
      brd_load = 1'b0;
   endtask

   task automatic test_reset();
      int seen;
      reset = 1'b0; en = 1'b1; brd_load = 1'b0; brd_int = 16'd0; brd_frac = 4'd0;
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++;
         if ({tick_ovs, tick_mid, tick_baud, ovs_cnt} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected %b", {tick_ovs, tick_mid, tick_baud, ovs_cnt}, 7'd0);
         end
      end
      reset = 1'b1;
      seen = -1;
      for (int i = 1; i <= 60; i++) begin
         step();
         n_cmp++;
         if ({tick_ovs, tick_mid, tick_baud, ovs_cnt} !== exp_vec) begin
            n_fail++;
            $display("FAIL reset_run: got %b expected %b", {tick_ovs, tick_mid, tick_baud, ovs_cnt}, exp_vec);
         end
         if (tick_ovs === 1'b1) begin seen = i; break; end
      end
      n_cmp++;
      if (seen !== 27) begin
         n_fail++;
         $display("FAIL reset_first_tick: got %0d expected %0d", seen, 27);
      end
   endtask

   task automatic test_basic();
      int baud1, baud2, mid_after;
      baud1 = -1; baud2 = -1; mid_after = -1;
      do_load(16'd4, 4'd0);
      for (int i = 1; i <= 140; i++) begin
         step();
         n_cmp++;
         if ({tick_ovs, tick_mid, tick_baud, ovs_cnt} !== exp_vec) begin
            n_fail++;
            $display("FAIL basic_cycle%0d: got %b expected %b", i, {tick_ovs, tick_mid, tick_baud, ovs_cnt}, exp_vec);
         end
         if (tick_baud === 1'b1) begin
            if (baud1 < 0) baud1 = i; else if (baud2 < 0) baud2 = i;
         end
         if (tick_mid === 1'b1 && baud1 > 0 && mid_after < 0) mid_after = i;
      end
      n_cmp++;
      if (baud1 !== 64 || baud2 - baud1 !== 64) begin
         n_fail++;
         $display("FAIL basic_baud: got %0d,%0d expected 64,128", baud1, baud2);
      end
      n_cmp++;
      if (mid_after - baud1 !== 32) begin
         n_fail++;
         $display("FAIL basic_mid: got %0d expected %0d", mid_after - baud1, 32);
      end
   endtask

   task automatic test_fractional();
      int t[0:19];
      int nt;
      int exp_p[0:4];
      int exp_sum;
`ifdef UART_BAUD_FRACTIONAL_EN
      exp_p = '{4, 4, 5, 4, 5}; exp_sum = 72;
`else
      exp_p = '{4, 4, 4, 4, 4}; exp_sum = 64;
`endif
      nt = 0;
      do_load(16'd4, 4'd8);
      for (int i = 1; i <= 120 && nt < 20; i++) begin
         step();
         n_cmp++;
         if ({tick_ovs, tick_mid, tick_baud, ovs_cnt} !== exp_vec) begin
            n_fail++;
            $display("FAIL frac_cycle%0d: got %b expected %b", i, {tick_ovs, tick_mid, tick_baud, ovs_cnt}, exp_vec);
         end
         if (tick_ovs === 1'b1) begin t[nt] = i; nt++; end
      end
      n_cmp++;
      if (nt !== 20) begin
         n_fail++;
         $display("FAIL frac_tick_count: got %0d expected %0d", nt, 20);
      end else begin
         for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (((k == 0) ? t[0] : t[k] - t[k-1]) !== exp_p[k]) begin
               n_fail++;
               $display("FAIL frac_period%0d: got %0d expected %0d", k, (k == 0) ? t[0] : t[k] - t[k-1], exp_p[k]);
            end
         end
         for (int k = 0; k + 16 < 20; k++) begin
            n_cmp++;
            if (t[k+16] - t[k] !== exp_sum) begin
               n_fail++;
               $display("FAIL frac_sum16_from%0d: got %0d expected %0d", k, t[k+16] - t[k], exp_sum);
            end
         end
      end
   endtask

   task automatic test_zero_div();
      int nbaud, novs;
      nbaud = 0; novs = 0;
      do_load(16'd0, 4'd0);
      for (int i = 1; i <= 32; i++) begin
         step();
         n_cmp++;
         if ({tick_ovs, tick_mid, tick_baud, ovs_cnt} !== exp_vec) begin
            n_fail++;
            $display("FAIL zero_cycle%0d: got %b expected %b", i, {tick_ovs, tick_mid, tick_baud, ovs_cnt}, exp_vec);
         end
         if (tick_ovs === 1'b1) novs++;
         if (tick_baud === 1'b1) nbaud++;
      end
      n_cmp++;
      if (novs !== 32 || nbaud !== 2) begin
         n_fail++;
         $display("FAIL zero_rates: got ovs=%0d baud=%0d expected ovs=32 baud=2", novs, nbaud);
      end
   endtask

   task automatic test_enable_pause();
      int seen;
      en = 1'b1;
      do_load(16'd4, 4'd0);
      for (int i = 0; i < 2; i++) step();
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         n_cmp++;
         if ({tick_ovs, tick_mid, tick_baud, ovs_cnt} !== exp_vec || tick_ovs !== 1'b0) begin
            n_fail++;
            $display("FAIL pause_hold: got %b expected %b", {tick_ovs, tick_mid, tick_baud, ovs_cnt}, exp_vec);
         end
      end
      en = 1'b1;
      seen = -1;
      for (int i = 1; i <= 10; i++) begin
         step();
         if (tick_ovs === 1'b1) begin seen = i; break; end
      end
      n_cmp++;
      if (seen !== 2) begin
         n_fail++;
         $display("FAIL pause_resume: got %0d expected %0d", seen, 2);
      end
   endtask

   task automatic test_load_terminal();
      int seen;
      en = 1'b1;
      do_load(16'd4, 4'd0);
      for (int i = 0; i < 15; i++) step();
      brd_load = 1'b1; brd_int = 16'd8; brd_frac = 4'd0;
      step();
      brd_load = 1'b0;
      n_cmp++;
      if (tick_ovs !== 1'b0 || ovs_cnt !== 4'd0 || {tick_ovs, tick_mid, tick_baud, ovs_cnt} !== exp_vec) begin
         n_fail++;
         $display("FAIL load_terminal: got %b expected %b", {tick_ovs, tick_mid, tick_baud, ovs_cnt}, 7'd0);
      end
      seen = -1;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (tick_ovs === 1'b1) begin seen = i; break; end
      end
      n_cmp++;
      if (seen !== 8) begin
         n_fail++;
         $display("FAIL load_next_tick: got %0d expected %0d", seen, 8);
      end
   endtask

   task automatic test_reset_mid();
      int seen;
      en = 1'b1;
      do_load(16'd4, 4'd0);
      for (int i = 0; i < 36; i++) step();
      n_cmp++;
      if (ovs_cnt !== 4'd9) begin
         n_fail++;
         $display("FAIL rstmid_phase: got %0d expected %0d", ovs_cnt, 9);
      end
      step(); step();
      reset = 1'b0;
      step();
      reset = 1'b1;
      n_cmp++;
      if ({tick_ovs, tick_mid, tick_baud, ovs_cnt} !== 7'd0) begin
         n_fail++;
         $display("FAIL rstmid_clear: got %b expected %b", {tick_ovs, tick_mid, tick_baud, ovs_cnt}, 7'd0);
      end
      seen = -1;
      for (int i = 1; i <= 60; i++) begin
         step();
         if (tick_ovs === 1'b1) begin seen = i; break; end
      end
      n_cmp++;
      if (seen !== 27) begin
         n_fail++;
         $display("FAIL rstmid_first_tick: got %0d expected %0d", seen, 27);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         reset    = ($urandom_range(0, 99) >= 2);
         brd_load = ($urandom_range(0, 99) < 3);
         brd_int  = 16'($urandom_range(0, 6));
         brd_frac = 4'($urandom_range(0, 15));
         en       = ($urandom_range(0, 99) < 85);
         step();
         n_cmp++;
         if ({tick_ovs, tick_mid, tick_baud, ovs_cnt} !== exp_vec) begin
            n_fail++;
            $display("FAIL random_cycle%0d: got %b expected %b", i, {tick_ovs, tick_mid, tick_baud, ovs_cnt}, exp_vec);
         end
      end
      reset = 1'b1; brd_load = 1'b0; en = 1'b1;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_fractional();
      test_zero_div();
      test_enable_pause();
      test_load_terminal();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
